apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_pkg.sv | 13 +
 rtl/apb_master_if.sv | 45 ++++
 rtl/apb_master.sv | 117 +++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master.
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals for apb_master.
interface apb_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_W-1:0]     PADDR;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  logic                  PREADY;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: one command in, one APB transfer, one response out.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic          PCLK,
  input logic          PRESETn,
  apb_master_if.master bus
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cmd_ready_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  // cmd_ready is its own register so it reads 0 throughout reset and rises on the first edge after.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            state_q     <= ST_SETUP;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            pwrite_q    <= bus.cmd_write;
            paddr_q     <= bus.cmd_addr;
            pwdata_q    <= bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_q     <= bus.cmd_write ? bus.cmd_strb  : '0;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
        end

        ST_ACCESS: begin
          if (bus.PREADY) begin
            state_q     <= ST_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.PSLVERR;
            rsp_rdata_q <= (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
            // This wait cycle is the TIMEOUT_CYCLES-th, so abort instead of incrementing.
            state_q     <= ST_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;

endmodule
